imem_fetch_responder: RTL and testbench

- Instruction-memory responder for the fetch stage. It answers the address issued by the program counter register.
- It accepts one fetch request at a time and returns the 32-bit instruction after a fixed latency.
- While a fetch is in flight it drives `ready_o` low. This signal feeds the PC's no-hazard/advance input (0 = stall, 1 = proceed).
- It includes a synchronous preload/write port, used by the bench and the boot loader.

---
 rtl/imem_fetch_responder.sv | 160 ++++++++++++++++
 tb/tb_imem_fetch_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch stage: one request at a time, fixed-latency response.
// Optional `IMEM_LAST_HIT_EN adds a one-entry last-address hit buffer with 1-cycle responses.
module imem_fetch_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   instr_q, instr_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          resp_load;
  logic          rd_bad;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          wr_ok;
  logic [AW-1:0] wr_idx;
  logic          hit;
  logic [31:0]   hit_instr;

  assign ready_o = (state_q != StBusy);
  assign valid_o = (state_q == StResp);
  assign err_o   = valid_o & err_q;
  assign instr_o = instr_q;
  assign accept  = req_i & start_i & ready_o;

  // Address decode for the captured fetch and for the preload port.
  assign rd_idx  = addr_q[AW+1:2];
  assign rd_bad  = (|addr_q[1:0]) | (|addr_q[31:AW+2]);
  assign rd_word = mem[rd_idx];

  assign wr_idx  = wr_addr_i[AW+1:2];
  assign wr_ok   = wr_en_i & ~(|wr_addr_i[1:0]) & ~(|wr_addr_i[31:AW+2]);

  // No reset on the array: contents survive reset so a preloaded program stays in place.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data_i;
    end
  end

`ifdef IMEM_LAST_HIT_EN
  logic          hit_vld_q, hit_vld_d;
  logic [31:0]   hit_addr_q;
  logic [31:0]   hit_instr_q;
  logic          fill;
  logic [AW-1:0] clr_idx;

  assign fill      = resp_load & ~rd_bad;
  assign hit       = hit_vld_q & (addr_i == hit_addr_q);
  assign hit_instr = hit_instr_q;
  // Compare writes against the entry that will be held after this edge.
  assign clr_idx   = fill ? addr_q[AW+1:2] : hit_addr_q[AW+1:2];

  always_comb begin
    hit_vld_d = hit_vld_q | fill;
    if (wr_ok && (wr_idx == clr_idx)) begin
      hit_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_vld_q   <= 1'b0;
      hit_addr_q  <= '0;
      hit_instr_q <= '0;
    end else begin
      hit_vld_q <= hit_vld_d;
      if (fill) begin
        hit_addr_q  <= addr_q;
        hit_instr_q <= rd_word;
      end
    end
  end
`else
  assign hit       = 1'b0;
  assign hit_instr = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    err_d     = err_q;
    resp_load = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          addr_d = addr_i;
          if (hit) begin
            state_d = StResp;
            instr_d = hit_instr;
            err_d   = 1'b0;
          end else begin
            state_d = StBusy;
            cnt_d   = CntInit;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d   = StResp;
          resp_load = 1'b1;
          // Faulting fetches return a NOP-equivalent zero word.
          instr_d   = rd_bad ? 32'h0 : rd_word;
          err_d     = rd_bad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: randomized preload/fetch traffic against a word-array
// reference model; a negedge monitor checks every response, ready_o timing and idle outputs.
module tb_imem_fetch_responder;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        ready_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  imem_fetch_responder #(
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .instr_o  (instr_o),
    .valid_o  (valid_o),
    .ready_o  (ready_o),
    .err_o    (err_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_lo = 0;
  int          busy_hi = 0;
  logic [31:0] last_instr = '0;
  logic [31:0] last_addr = '0;
  bit          mon_en = 1'b0;
  bit          hit_v = 1'b0;
  logic [31:0] hit_a = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic bit addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (addr_ok(a)) begin
      ref_mem[a[AW+1:2]] = d;
      if (hit_v && a == hit_a) hit_v = 1'b0;
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    model_write(a, d);
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  // Called at a negedge where the DUT can accept; returns at the negedge of the response cycle.
  task automatic issue(input logic [31:0] a, input bit collide, input bit drop_start);
    exp_t        e;
    int          lat;
    logic [31:0] nd;
    lat = LATENCY;
    if (addr_ok(a)) begin
      e.instr = ref_mem[a[AW+1:2]];
      e.err   = 1'b0;
    end else begin
      e.instr = '0;
      e.err   = 1'b1;
    end
`ifdef IMEM_LAST_HIT_EN
    if (hit_v && a == hit_a) lat = 0;
    if (!e.err) begin
      hit_v = 1'b1;
      hit_a = a;
    end
`endif
    e.due   = cyc + 1 + lat;
    busy_lo = cyc + 1;
    busy_hi = cyc + 1 + lat;
    sb.push_back(e);
    last_addr = a;
    req_i   = 1'b1;
    addr_i  = a;
    start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    if (drop_start) start_i = 1'b0;
    else req_i = 1'b0;
    addr_i = $urandom();
    for (int i = 0; i < lat; i++) begin
      if (collide && i == lat - 1) begin
        nd        = $urandom();
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = nd;
        model_write(a, nd);
      end
      @(negedge clk_i);
      wr_en_i = 1'b0;
    end
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_i && mon_en) begin
      check("ready_o", 32'(ready_o), 32'(!(cyc >= busy_lo && cyc < busy_hi)));
      if (valid_o) begin
        if (sb.size() == 0) begin
          check("valid_o with no pending fetch", 32'(valid_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check("instr_o", instr_o, e.instr);
          check("err_o", 32'(err_o), 32'(e.err));
          check("response cycle", 32'(cyc), 32'(e.due));
          last_instr = e.instr;
        end
      end else begin
        check("idle err_o", 32'(err_o), 32'd0);
        check("held instr_o", instr_o, last_instr);
        if (sb.size() > 0 && cyc >= sb[0].due) begin
          check("valid_o on time", 32'(valid_o), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] a;
    int          k;
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset instr_o", instr_o, 32'd0);
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset ready_o", 32'(ready_o), 32'd1);
    check("reset err_o", 32'(err_o), 32'd0);
    rst_i  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < int'(DEPTH); i++) wr(32'(i * 4), $urandom());

    // Basic fetch of a known word.
    wr(32'h0000_000C, 32'h8C22_0004);
    issue(32'h0000_000C, 1'b0, 1'b0);
    repeat (1) @(negedge clk_i);

    // Back-to-back fetches.
    issue(32'h0, 1'b0, 1'b0);
    issue(32'h4, 1'b0, 1'b0);
    issue(32'h8, 1'b0, 1'b0);
    @(negedge clk_i);

    // Misaligned and out-of-range fetches, and dropped preload writes.
    issue(32'h6, 1'b0, 1'b0);
    @(negedge clk_i);
    issue(32'h400, 1'b0, 1'b0);
    @(negedge clk_i);
    wr(32'h0000_000D, 32'hDEAD_0001);
    wr(32'h0000_040C, 32'hDEAD_0002);
    issue(32'h0000_000C, 1'b0, 1'b0);
    @(negedge clk_i);

    // Run enable dropped mid-fetch with req_i held high.
    issue(32'h20, 1'b0, 1'b1);
    repeat (4) @(negedge clk_i);
    req_i   = 1'b0;
    start_i = 1'b1;
    @(negedge clk_i);

    // Repeat fetch, then rewrite the word and fetch again.
    issue(32'h10, 1'b0, 1'b0);
    @(negedge clk_i);
    issue(32'h10, 1'b0, 1'b0);
    @(negedge clk_i);
    wr(32'h10, 32'h1234_5678);
    issue(32'h10, 1'b0, 1'b0);
    @(negedge clk_i);

    // Write to the fetched word on the response edge returns the old word.
    issue(32'h14, 1'b1, 1'b0);
    @(negedge clk_i);
    issue(32'h14, 1'b0, 1'b0);
    @(negedge clk_i);

    for (int n = 0; n < 300; n++) begin
      k = int'($urandom_range(0, 12));
      if (k < 3) begin
        a = (k == 0) ? 32'($urandom_range(0, DEPTH * 8 - 1)) : 32'($urandom_range(0, DEPTH - 1) * 4);
        wr(a, $urandom());
      end else begin
        if (k < 8)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (k < 10) a = last_addr;
        else if (k == 10) a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
        else if (k == 11) a = ($urandom() | 32'h400) & 32'hFFFF_FFFC;
        else              a = 32'($urandom_range(0, DEPTH - 1) * 4);
        issue(a, (k == 12), 1'b0);
        if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end
    end
    repeat (2) @(negedge clk_i);

    // Reset asserted mid-fetch aborts it.
    a       = (hit_v && hit_a == 32'h3FC) ? 32'h3F8 : 32'h3FC;
    busy_lo = cyc + 1;
    busy_hi = cyc + 1 + LATENCY;
    req_i   = 1'b1;
    start_i = 1'b1;
    addr_i  = a;
    @(posedge clk_i);
    #2;
    req_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("async reset instr_o", instr_o, 32'd0);
    check("async reset valid_o", 32'(valid_o), 32'd0);
    check("async reset ready_o", 32'(ready_o), 32'd1);
    check("async reset err_o", 32'(err_o), 32'd0);
    sb.delete();
    busy_lo    = 0;
    busy_hi    = 0;
    last_instr = '0;
    hit_v      = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (6) @(negedge clk_i);
    issue(32'h0000_000C, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
